// File: rtl/nios2_mul_result_combiner.sv
// Combines four registered 16x16 partial products into the 32-bit MUL/MULX* result.
// Operands are captured on a valid/ready handshake, summed over a small FSM, and held until taken.
module nios2_mul_result_combiner #(
    parameter int unsigned RESULT_W = 32,
    parameter int unsigned PP_W     = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [RESULT_W-1:0] in_src1,
    input  logic [RESULT_W-1:0] in_src2,
    input  logic [PP_W-1:0]     in_p1,
    input  logic [PP_W-1:0]     in_p2,
    input  logic [PP_W-1:0]     in_p3,
    input  logic [PP_W-1:0]     in_p4,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_result
);

    localparam int unsigned HALF_W = RESULT_W / 2;
    localparam int unsigned S_W    = 2 * RESULT_W - HALF_W + 1;
    localparam int unsigned CY_W   = S_W - RESULT_W;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUM_LO = 2'd1,
        SUM_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q;
    logic [RESULT_W-1:0]   src1_q, src2_q;
    logic [PP_W-1:0]       p1_q, p2_q, p3_q, p4_q;
    logic [CY_W-1:0]       s_hi_q, s_hi_d;
    logic                  out_valid_d;
    logic [RESULT_W-1:0]   out_result_d;

    logic                  accept_c;
    logic [S_W-1:0]        s_c;
    logic                  sa_c, sb_c;
    logic [RESULT_W-1:0]   h_c;

    assign in_ready = (state_q == IDLE) && !flush;
    assign accept_c = in_valid && in_ready;

    // Low sum of the three lower-order partial products; carries above bit 31 feed the high word.
    assign s_c = S_W'(p1_q) + (S_W'(p2_q) << HALF_W) + (S_W'(p3_q) << HALF_W);

    // Signed operands contribute -2^32*other_operand, i.e. subtract it from the high word.
    assign sa_c = src1_q[RESULT_W-1] && ((op_q == OP_MULXSU) || (op_q == OP_MULXSS));
    assign sb_c = src2_q[RESULT_W-1] && (op_q == OP_MULXSS);
    assign h_c  = RESULT_W'(p4_q) + RESULT_W'(s_hi_q)
                - (sa_c ? src2_q : '0) - (sb_c ? src1_q : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            s_hi_q     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            state_q    <= state_d;
            s_hi_q     <= s_hi_d;
            out_valid  <= out_valid_d;
            out_result <= out_result_d;
        end
    end

    // Operand and partial-product capture on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            p3_q   <= '0;
            p4_q   <= '0;
        end else if (accept_c) begin
            op_q   <= in_op;
            src1_q <= in_src1;
            src2_q <= in_src2;
            p1_q   <= in_p1;
            p2_q   <= in_p2;
            p3_q   <= in_p3;
            p4_q   <= in_p4;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_hi_d       = s_hi_q;
        out_valid_d  = out_valid;
        out_result_d = out_result;
        unique case (state_q)
            IDLE: begin
                if (accept_c) state_d = SUM_LO;
            end
            SUM_LO: begin
                s_hi_d = s_c[S_W-1:RESULT_W];
                if (op_q == OP_MUL) begin
                    state_d      = DONE;
                    out_valid_d  = 1'b1;
                    out_result_d = s_c[RESULT_W-1:0];
                end else begin
                    state_d = SUM_HI;
                end
            end
            SUM_HI: begin
                state_d      = DONE;
                out_valid_d  = 1'b1;
                out_result_d = h_c;
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over accept and output transfer; the result register keeps its old value.
        if (flush) begin
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            out_result_d = out_result;
        end
    end

endmodule

// File: tb/tb_nios2_mul_result_combiner.sv
// Directed checks of nios2_mul_result_combiner: products, latency, backpressure, flush, async reset.
module tb_nios2_mul_result_combiner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1, in_src2;
    logic [31:0] in_p1, in_p2, in_p3, in_p4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int n_checks = 0;
    int n_errors = 0;

    nios2_mul_result_combiner #(.RESULT_W(32), .PP_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .in_p4      (in_p4),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operation and returns #1 after the accepting edge.
    task automatic start_op(input string tag, input logic [1:0] op,
                            input logic [31:0] s1, input logic [31:0] s2,
                            input logic [31:0] p1, input logic [31:0] p2,
                            input logic [31:0] p3, input logic [31:0] p4);
        int n;
        in_op = op; in_src1 = s1; in_src2 = s2;
        in_p1 = p1; in_p2 = p2; in_p3 = p3; in_p4 = p4;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Latency counts cycles from the accept cycle (cycle 0) to the first out_valid cycle.
    task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp);
        int lat;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, out_result, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] p1, input logic [31:0] p2,
                          input logic [31:0] p3, input logic [31:0] p4,
                          input int exp_lat, input logic [31:0] exp);
        start_op(tag, op, s1, s2, p1, p2, p3, p4);
        wait_result(tag, exp_lat, exp);
        tick();
        check({tag, "_xfer_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_op = 2'b00;
        in_src1 = '0; in_src2 = '0; in_p1 = '0; in_p2 = '0; in_p3 = '0; in_p4 = '0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        run_op("mul_small", 2'b00, 32'h00010003, 32'h00020005, 32'hF, 32'h6, 32'h5, 32'h2, 2, 32'h000B000F);
        run_op("mulxuu_small", 2'b01, 32'h00010003, 32'h00020005, 32'hF, 32'h6, 32'h5, 32'h2, 3, 32'h00000002);
        run_op("mulxuu_neg", 2'b01, 32'hFFFFFFFF, 32'h2, 32'h1FFFE, 32'h0, 32'h1FFFE, 32'h0, 3, 32'h00000001);
        run_op("mulxsu_neg", 2'b10, 32'hFFFFFFFF, 32'h2, 32'h1FFFE, 32'h0, 32'h1FFFE, 32'h0, 3, 32'hFFFFFFFF);
        run_op("mulxss_neg", 2'b11, 32'hFFFFFFFF, 32'h2, 32'h1FFFE, 32'h0, 32'h1FFFE, 32'h0, 3, 32'hFFFFFFFF);
        run_op("mul_neg", 2'b00, 32'hFFFFFFFF, 32'h2, 32'h1FFFE, 32'h0, 32'h1FFFE, 32'h0, 2, 32'hFFFFFFFE);
        // (-2^31)*(-2^31) = 2^62 and (-2^31)*(2^31) = -2^62
        run_op("mulxss_min", 2'b11, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h40000000, 3, 32'h40000000);
        run_op("mulxsu_min", 2'b10, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h40000000, 3, 32'hC0000000);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        start_op("bp", 2'b00, 32'h00010003, 32'h00020005, 32'hF, 32'h6, 32'h5, 32'h2);
        wait_result("bp", 2, 32'h000B000F);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_result", out_result, 32'h000B000F);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Flush while summing.
        start_op("fl_lo", 2'b01, 32'h00010003, 32'h00020005, 32'hF, 32'h6, 32'h5, 32'h2);
        flush = 1'b1;
        #1;
        check("fl_lo_in_ready_forced", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_lo_out_valid", 32'(out_valid), 32'd0);
        check("fl_lo_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fl_lo_no_result", 32'(out_valid), 32'd0);
        end

        // Flush in DONE with out_ready high: no transfer, back to idle.
        start_op("fl_done", 2'b01, 32'hFFFFFFFF, 32'h2, 32'h1FFFE, 32'h0, 32'h1FFFE, 32'h0);
        wait_result("fl_done", 3, 32'h00000001);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("fl_done_out_valid", 32'(out_valid), 32'd0);
        check("fl_done_in_ready", 32'(in_ready), 32'd1);
        run_op("after_flush", 2'b10, 32'hFFFFFFFF, 32'h2, 32'h1FFFE, 32'h0, 32'h1FFFE, 32'h0, 3, 32'hFFFFFFFF);

        // Asynchronous reset while in SUM_HI.
        start_op("arst", 2'b11, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h40000000);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_result", out_result, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("arst_no_stale", 32'(out_valid), 32'd0);
        end
        run_op("after_reset", 2'b00, 32'h00010003, 32'h00020005, 32'hF, 32'h6, 32'h5, 32'h2, 2, 32'h000B000F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
